piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out stage placed directly upstream of the team's serial sequence detectors, such as the overlapping Mealy "1001" detector.
- Accepts P_WIDTH-bit words over a valid/ready handshake.
- Emits one bit per i_clk on o_x; the detector samples o_x as its serial input.
- Supports zero-bubble back-to-back words, so multi-word patterns stay contiguous across word boundaries.

Parameters:
P_WIDTH, 8, word width in bits; legal range 2..32.
P_MSB_FIRST, 1, 1 = shift out bit P_WIDTH-1 first; 0 = shift out bit 0 first.
P_IDLE_BIT, 0, value driven on o_x whenever no word is being shifted.

Ports:
i_clk  input  1  clock; all state changes on rising edge.
i_rst_b  input  1  reset: asynchronous assert, active-low; synchronous release is the integrator's responsibility.
i_data  input  P_WIDTH  parallel word; sampled only on accept.
i_valid  input  1  upstream offers i_data.
o_ready  output  1  block can accept a word this cycle (combinational from state).
o_x  output  1  serial bit (registered).
o_x_valid  output  1  o_x carries a payload bit this cycle (registered).
o_word_done  output  1  one-cycle pulse that coincides with the last bit of each word on o_x.
o_busy  output  1  high while in SHIFT.

Behaviour:
- Reset values (i_rst_b low): state IDLE, shift register 0, bit counter 0, o_x = P_IDLE_BIT, o_x_valid = 0, o_word_done = 0, o_busy = 0. Because o_ready is combinational from state, o_ready = 1 during reset.
- Reset mid-word: the word in flight is discarded immediately; no partial output after release.
- States: IDLE and SHIFT, 1-bit encoding (IDLE = 0, SHIFT = 1).
- Accept = i_valid & o_ready, evaluated at the rising edge. i_data is captured only on accept; changes on i_data at other times are ignored.
- o_ready = 1 in IDLE, and 1 in SHIFT only when the bit counter is at P_WIDTH-1 (last bit on o_x). Otherwise 0.
- Latency: the first bit of an accepted word appears on o_x, with o_x_valid = 1, in the cycle immediately after the accept edge.
- SHIFT operation:
  - One bit per cycle. The bit counter counts 0..P_WIDTH-1; counter width is $clog2(P_WIDTH).
  - MSB-first shifts the register left; LSB-first shifts it right.
  - Vacated bits are filled with 0.
- End of word (counter = P_WIDTH-1):
  - o_word_done = 1 in that cycle.
  - If an accept occurs at the next edge: reload the register, reset the counter to 0, stay in SHIFT. The next word's first bit follows with no gap and o_x_valid stays 1.
  - If no accept: go to IDLE. Next cycle o_x = P_IDLE_BIT, o_x_valid = 0, o_busy = 0.
- In IDLE: o_x holds P_IDLE_BIT, o_x_valid = 0, o_word_done = 0.
- i_valid held high while o_ready = 0 is legal. The word is accepted on the first cycle o_ready = 1. No data loss or duplication.
- Upstream may deassert i_valid without an accept; no state change results.
- Throughput: exactly P_WIDTH cycles per word in back-to-back operation.

Decomposition:
- Shared package, also included by the detector family:
  - state localparams p_state_IDLE = 1'b0, p_state_SHIFT = 1'b1;
  - default width constant P_SER_WIDTH = 8.
- Single module; no sub-module is needed. Counter, shift register and FSM live in three always blocks:
  - combinational next-state / o_ready logic;
  - sequential state register;
  - sequential datapath and outputs.
- Integration: o_x drives the detector's i_x directly. o_x_valid is available to gate detector output in the wrapper.

Test Plan:
- Single word, P_WIDTH=8, MSB-first: i_data = 8'h93, one-cycle i_valid.
  -> o_x = 1,0,0,1,0,0,1,1 on cycles 1..8 after accept; o_x_valid = 1 for exactly those 8 cycles; o_word_done only on cycle 8; then o_x = 0, o_x_valid = 0.
- Back-to-back: 8'h93 then 8'h9C, i_valid held high.
  -> second accept on cycle 8 (o_ready = 1 there); 16 consecutive valid bits 1001_0011_1001_1100 with no gap; two o_word_done pulses, on cycles 8 and 16.
- LSB-first (P_MSB_FIRST=0): i_data = 8'h01.
  -> o_x = 1 then seven 0s.
- Stall: i_valid asserted with 8'hFF at bit 2 of a word in flight.
  -> o_ready = 0 until the last bit; 8'hFF is accepted there and serialized once; the current word is uncorrupted.
- Reset mid-word: assert i_rst_b low during bit 3 of 8'hAA.
  -> o_x_valid = 0, o_x = 0, o_busy = 0, o_word_done = 0 immediately and asynchronously.
  -> after release, o_ready = 1 and no residual bits appear.
- Idle with P_IDLE_BIT = 1, no i_valid for 20 cycles.
  -> o_x = 1, o_x_valid = 0, o_busy = 0 throughout.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared constants for the serializer and the serial detector family.
package piso_serializer_pkg;

  // One-bit state encoding shared with the detectors.
  localparam logic p_state_IDLE  = 1'b0;
  localparam logic p_state_SHIFT = 1'b1;

  // Default parallel word width.
  localparam int P_SER_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = p_state_IDLE,
    ST_SHIFT = p_state_SHIFT
  } ser_state_t;

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage.
// Takes P_WIDTH-bit words over valid/ready and emits one bit per clock on o_x.
// A new word can be taken on the last bit of the current one, so consecutive
// words leave the block with no idle bit between them.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int P_WIDTH     = P_SER_WIDTH,  // legal range 2..32
  parameter bit P_MSB_FIRST = 1'b1,
  parameter bit P_IDLE_BIT  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_b,
  input  logic [P_WIDTH-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_x,
  output logic               o_x_valid,
  output logic               o_word_done,
  output logic               o_busy
);

  localparam int               CNT_W        = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(P_WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(P_WIDTH - 2);

  ser_state_t         state;
  ser_state_t         state_nxt;
  logic [P_WIDTH-1:0] shift_reg;    // bits still to be shown after the current o_x
  logic [CNT_W-1:0]   bit_cnt;      // index of the bit currently on o_x
  logic               at_last;
  logic               accept;

  // Next state and handshake: ready in IDLE, or while the last bit is on o_x.
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
    at_last   = (bit_cnt == LAST_CNT);
    o_ready   = (state == ST_IDLE) || ((state == ST_SHIFT) && at_last);
    accept    = i_valid && o_ready;
    state_nxt = state;
    if (accept) begin
      state_nxt = ST_SHIFT;
    end else if ((state == ST_SHIFT) && at_last) begin
      state_nxt = ST_IDLE;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!i_rst_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: load on accept, shift while mid-word, otherwise park at the idle level.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      o_x         <= P_IDLE_BIT;
      o_x_valid   <= 1'b0;
      o_word_done <= 1'b0;
    end else if (accept) begin
      // The first bit goes straight to o_x; the register keeps the remainder.
      if (P_MSB_FIRST) begin
        o_x       <= i_data[P_WIDTH-1];
        shift_reg <= i_data << 1;
      end else begin
        o_x       <= i_data[0];
        shift_reg <= i_data >> 1;
      end
      bit_cnt     <= '0;
      o_x_valid   <= 1'b1;
      o_word_done <= 1'b0;
    end else if ((state == ST_SHIFT) && !at_last) begin
      if (P_MSB_FIRST) begin
        o_x       <= shift_reg[P_WIDTH-1];
        shift_reg <= shift_reg << 1;
      end else begin
        o_x       <= shift_reg[0];
        shift_reg <= shift_reg >> 1;
      end
      bit_cnt     <= bit_cnt + 1'b1;
      o_x_valid   <= 1'b1;
      // Flag lands together with the last bit on o_x.
      o_word_done <= (bit_cnt == PRE_LAST_CNT);
    end else begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      o_x         <= P_IDLE_BIT;
      o_x_valid   <= 1'b0;
      o_word_done <= 1'b0;
    end
  end

  assign o_busy = (state == ST_SHIFT);

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: dut_a is 8-bit MSB-first with idle bit 0,
// dut_b is 8-bit LSB-first with idle bit 1.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       va, vb;
  logic [7:0] da, db;
  logic       ready_a, x_a, xv_a, done_a, busy_a;
  logic       ready_b, x_b, xv_b, done_b, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.P_WIDTH(8), .P_MSB_FIRST(1'b1), .P_IDLE_BIT(1'b0)) dut_a (
    .i_clk(clk), .i_rst_b(rst_b), .i_data(da), .i_valid(va),
    .o_ready(ready_a), .o_x(x_a), .o_x_valid(xv_a), .o_word_done(done_a), .o_busy(busy_a)
  );

  piso_serializer #(.P_WIDTH(8), .P_MSB_FIRST(1'b0), .P_IDLE_BIT(1'b1)) dut_b (
    .i_clk(clk), .i_rst_b(rst_b), .i_data(db), .i_valid(vb),
    .o_ready(ready_b), .o_x(x_b), .o_x_valid(xv_b), .o_word_done(done_b), .o_busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle vector: inputs before the edge, ready before the edge, outputs after it.
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       x;
    logic       xv;
    logic       done;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic v, logic [7:0] d, logic rdy, logic x, logic xv, logic done);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.x = x; r.xv = xv; r.done = done;
    tbl.push_back(r);
  endfunction

  // Reference model: per DUT, a queue of {last, bit} entries. Entry 0 is the
  // bit currently on o_x; the block can take a word when at most that one remains.
  logic [1:0] mq[2][$];

  function automatic void push_word(int idx, logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      mq[idx].push_back({(k == 7), (idx == 0) ? w[7-k] : w[k]});
    end
  endfunction

  function automatic logic [3:0] exp_out(int idx);
    logic idle_bit;
    idle_bit = (idx == 0) ? 1'b0 : 1'b1;
    if (mq[idx].size() == 0) return {idle_bit, 3'b000};
    return {mq[idx][0][0], 1'b1, mq[idx][0][1], 1'b1};  // {x, xv, done, busy}
  endfunction

  task automatic model_cycle();
    logic ra, rb, acc_a, acc_b;
    logic [7:0] wa, wb;
    va = ($urandom_range(0, 9) < 6);
    vb = ($urandom_range(0, 9) < 4);
    da = 8'($urandom);
    db = 8'($urandom);
    wa = da;
    wb = db;
    ra = (mq[0].size() <= 1);
    rb = (mq[1].size() <= 1);
    check("rnd_ready_a", ready_a, ra);
    check("rnd_ready_b", ready_b, rb);
    acc_a = va && ra;
    acc_b = vb && rb;
    @(posedge clk); #1;
    if (mq[0].size() > 0) void'(mq[0].pop_front());
    if (mq[1].size() > 0) void'(mq[1].pop_front());
    if (acc_a) push_word(0, wa);
    if (acc_b) push_word(1, wb);
    check("rnd_out_a", {x_a, xv_a, done_a, busy_a}, exp_out(0));
    check("rnd_out_b", {x_b, xv_b, done_b, busy_b}, exp_out(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] stream;

    rst_b = 1'b0;
    va = 1'b0; vb = 1'b0; da = 8'h00; db = 8'h00;

    // Reset state.
    #12;
    check("rst_out_a",   {x_a, xv_a, done_a, busy_a}, 4'b0000);
    check("rst_ready_a", ready_a, 1'b1);
    check("rst_out_b",   {x_b, xv_b, done_b, busy_b}, 4'b1000);
    check("rst_ready_b", ready_b, 1'b1);
    #5 rst_b = 1'b1;
    @(posedge clk); #1;

    // Single word 0x93, then back-to-back 0x93 / 0x9C with valid held.
    add(1, 8'h93, 1, 1, 1, 0);
    add(0, 8'hFF, 0, 0, 1, 0);
    add(0, 8'hFF, 0, 0, 1, 0);
    add(0, 8'hFF, 0, 1, 1, 0);
    add(0, 8'hFF, 0, 0, 1, 0);
    add(0, 8'hFF, 0, 0, 1, 0);
    add(0, 8'hFF, 0, 1, 1, 0);
    add(0, 8'hFF, 0, 1, 1, 1);
    add(0, 8'hFF, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0);
    add(1, 8'h93, 1, 1, 1, 0);
    add(1, 8'h9C, 0, 0, 1, 0);
    add(1, 8'h9C, 0, 0, 1, 0);
    add(1, 8'h9C, 0, 1, 1, 0);
    add(1, 8'h9C, 0, 0, 1, 0);
    add(1, 8'h9C, 0, 0, 1, 0);
    add(1, 8'h9C, 0, 1, 1, 0);
    add(1, 8'h9C, 0, 1, 1, 1);
    add(1, 8'h9C, 1, 1, 1, 0);
    add(0, 8'h00, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 0);
    add(0, 8'h00, 0, 1, 1, 0);
    add(0, 8'h00, 0, 1, 1, 0);
    add(0, 8'h00, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1);
    add(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      va = tbl[i].v;
      da = tbl[i].d;
      check($sformatf("tbl_ready[%0d]", i), ready_a, tbl[i].rdy);
      @(posedge clk); #1;
      check($sformatf("tbl_out[%0d]", i), {x_a, xv_a, done_a}, {tbl[i].x, tbl[i].xv, tbl[i].done});
    end

    // dut_b has stayed idle all along; watch it for 20 more cycles.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_b", {x_b, xv_b, busy_b}, 3'b100);
    end

    // LSB-first 0x01: a 1 then seven 0s, then back to the idle level 1.
    vb = 1'b1; db = 8'h01;
    @(posedge clk); #1;
    vb = 1'b0; db = 8'h00;
    check("lsb_bit0", {x_b, xv_b, done_b}, 3'b110);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("lsb_bit%0d", k), {x_b, xv_b, done_b}, {1'b0, 1'b1, (k == 7)});
    end
    @(posedge clk); #1;
    check("lsb_after", {x_b, xv_b, busy_b}, 3'b100);

    // Stall: 0xFF offered at bit 2 of 0xAA waits for the last bit, then follows once.
    va = 1'b1; da = 8'hAA;
    @(posedge clk); #1;
    va = 1'b0;
    stream = '0;
    for (int k = 0; k < 16; k++) begin
      stream = {stream[14:0], x_a};
      check("stall_xv", xv_a, 1'b1);
      if (k == 2) begin va = 1'b1; da = 8'hFF; end
      if (k >= 2 && k <= 7) check("stall_ready", ready_a, (k == 7));
      if (k == 8) begin va = 1'b0; da = 8'h00; end
      @(posedge clk); #1;
    end
    check("stall_stream", stream, 16'hAAFF);
    check("stall_after", {x_a, xv_a, busy_a}, 3'b000);

    // Reset during bit 3 of 0xAA: outputs clear at once, nothing left afterwards.
    va = 1'b1; da = 8'hAA;
    @(posedge clk); #1;
    va = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_busy", busy_a, 1'b1);
    #2 rst_b = 1'b0;
    #1;
    check("mid_rst_out",   {x_a, xv_a, done_a, busy_a}, 4'b0000);
    check("mid_rst_ready", ready_a, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    mq[0].delete();
    mq[1].delete();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("post_rst_out",   {x_a, xv_a, done_a, busy_a}, 4'b0000);
      check("post_rst_ready", ready_a, 1'b1);
    end

    // Random traffic on both instances against the queue model.
    for (int i = 0; i < 600; i++) model_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_piso_serializer
